// File: rtl/my_sub.sv
// my_sub: slice-serial two's-complement subtractor, dout = ain - bin.
// The operands are processed SLICE_WIDTH bits per cycle, least-significant
// slice first, as ain + ~bin + 1. Completion raises a one-cycle done pulse
// together with the unsigned borrow and signed overflow flags.
// Optional build macro MY_SUB_SATURATE_EN: on signed overflow, dout clamps to
// the most positive or most negative value, chosen by the sign of ain.
module my_sub #(
    parameter int BIT_WIDTH   = 32,
    parameter int SLICE_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [BIT_WIDTH-1:0] ain,
    input  logic [BIT_WIDTH-1:0] bin,
    output logic                 busy,
    output logic                 done,
    output logic [BIT_WIDTH-1:0] dout,
    output logic                 borrow,
    output logic                 overflow
);

    localparam int N     = BIT_WIDTH / SLICE_WIDTH;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                 state;
    logic [BIT_WIDTH-1:0]   a_r;
    logic [BIT_WIDTH-1:0]   nb_r;
    logic [BIT_WIDTH-1:0]   res_r;
    logic                   c;
    logic [IDX_W-1:0]       idx;

    logic [SLICE_WIDTH-1:0] a_sl;
    logic [SLICE_WIDTH-1:0] nb_sl;
    logic [SLICE_WIDTH:0]   slice_sum;
    logic [BIT_WIDTH-1:0]   diff_full;
    logic                   last;
    logic                   ovf_next;
    logic [BIT_WIDTH-1:0]   dout_next;
    int                     base;

`ifdef MY_SUB_SATURATE_EN
    // Clamp toward the sign of the minuend when the signed result overflowed.
    function automatic logic [BIT_WIDTH-1:0] sat_diff(
        input logic [BIT_WIDTH-1:0] d,
        input logic                 ovf,
        input logic                 a_neg
    );
        logic [BIT_WIDTH-1:0] lim;
        lim = {1'b0, {(BIT_WIDTH-1){1'b1}}};
        if (!ovf)
            return d;
        else if (a_neg)
            return ~lim;
        else
            return lim;
    endfunction
`endif

    // Current slice add and the full-width difference as it stands after this slice.
    always_comb begin
        base      = int'(idx) * SLICE_WIDTH;
        a_sl      = a_r[base +: SLICE_WIDTH];
        nb_sl     = nb_r[base +: SLICE_WIDTH];
        slice_sum = {1'b0, a_sl} + {1'b0, nb_sl} + {{SLICE_WIDTH{1'b0}}, c};
        diff_full = res_r;
        diff_full[base +: SLICE_WIDTH] = slice_sum[SLICE_WIDTH-1:0];
        last      = (idx == IDX_W'(N - 1));
        // The subtrahend sign is the complement of the stored inverted operand's sign.
        ovf_next  = (a_r[BIT_WIDTH-1] != ~nb_r[BIT_WIDTH-1]) &&
                    (diff_full[BIT_WIDTH-1] != a_r[BIT_WIDTH-1]);
`ifdef MY_SUB_SATURATE_EN
        dout_next = sat_diff(diff_full, ovf_next, a_r[BIT_WIDTH-1]);
`else
        dout_next = diff_full;
`endif
    end

    // Control FSM plus slice datapath; results are published only on the final slice.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            a_r      <= '0;
            nb_r     <= '0;
            res_r    <= '0;
            c        <= 1'b0;
            idx      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            dout     <= '0;
            borrow   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r   <= ain;
                        nb_r  <= ~bin;
                        res_r <= '0;
                        c     <= 1'b1;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    res_r <= diff_full;
                    c     <= slice_sum[SLICE_WIDTH];
                    idx   <= idx + IDX_W'(1);
                    if (last) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        dout     <= dout_next;
                        borrow   <= ~slice_sum[SLICE_WIDTH];
                        overflow <= ovf_next;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_my_sub.sv
// tb_my_sub: directed vector table plus hand-written handshake/reset sequences.
module tb_my_sub;

    localparam int BW = 32;
    localparam int N  = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [BW-1:0] ain;
    logic [BW-1:0] bin;
    logic          busy;
    logic          done;
    logic [BW-1:0] dout;
    logic          borrow;
    logic          overflow;

    int pass_cnt = 0;
    int total    = 0;

    my_sub #(.BIT_WIDTH(BW), .SLICE_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .start(start), .ain(ain), .bin(bin),
        .busy(busy), .done(done), .dout(dout), .borrow(borrow), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [BW-1:0] a;
        logic [BW-1:0] b;
        logic [BW-1:0] d;
        logic          brw;
        logic          ovf;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        else
            pass_cnt++;
    endtask

    // Wait (bounded) for done; cyc counts edges since the accepting edge.
    task automatic wait_done(input int cyc0, output int cyc);
        cyc = cyc0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            cyc++;
            if (done) return;
        end
        cyc = -1;
    endtask

    task automatic do_op(input string name, input logic [BW-1:0] a, input logic [BW-1:0] b,
                         input logic [BW-1:0] ed, input logic eb, input logic eo);
        int cyc;
        @(posedge clk); #1;
        start = 1'b1; ain = a; bin = b;
        @(posedge clk); #1;
        start = 1'b0;
        chk({name, " busy"}, 32'(busy), 32'd1);
        wait_done(0, cyc);
        chk({name, " latency"}, 32'(cyc), 32'(N));
        chk({name, " dout"}, dout, ed);
        chk({name, " borrow"}, 32'(borrow), 32'(eb));
        chk({name, " overflow"}, 32'(overflow), 32'(eo));
    endtask

    initial begin
        int  cyc;
        logic seen_done;

        vecs[0] = '{32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b0, 1'b0};
        vecs[1] = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0};
`ifdef MY_SUB_SATURATE_EN
        vecs[2] = '{32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1};
        vecs[3] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b1};
`else
        vecs[2] = '{32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1};
        vecs[3] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b1};
`endif
        vecs[4] = '{32'h0000_0100, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0};
        vecs[5] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b0};

        reset = 1'b1; start = 1'b0; ain = '0; bin = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst dout", dout, 32'd0);
        chk("rst borrow", 32'(borrow), 32'd0);
        chk("rst overflow", 32'(overflow), 32'd0);

        for (int i = 0; i < 6; i++)
            do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].brw, vecs[i].ovf);

        // Done pulse lasts one cycle and result holds afterwards.
        @(posedge clk); #1;
        chk("done width", 32'(done), 32'd0);
        chk("dout hold", dout, 32'h7FFF_FFFF);

        // start while busy is ignored
        @(posedge clk); #1;
        start = 1'b1; ain = 32'd10; bin = 32'd4;
        @(posedge clk); #1;
        ain = 32'd1; bin = 32'd1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(1, cyc);
        chk("busy-ignore latency", 32'(cyc), 32'(N));
        chk("busy-ignore dout", dout, 32'd6);

        // start in the done cycle is accepted back-to-back
        start = 1'b1; ain = 32'd9; bin = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b busy", 32'(busy), 32'd1);
        wait_done(0, cyc);
        chk("b2b latency", 32'(cyc), 32'(N));
        chk("b2b dout", dout, 32'd0);
        chk("b2b borrow", 32'(borrow), 32'd0);

        // leave nonzero outputs so the abort visibly clears them
        do_op("pre-abort", 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0);

        // reset in the second RUN cycle aborts; start held during reset ignored
        @(posedge clk); #1;
        start = 1'b1; ain = 32'h1234_5678; bin = 32'h1111_1111;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort dout", dout, 32'd0);
        chk("abort borrow", 32'(borrow), 32'd0);
        chk("abort overflow", 32'(overflow), 32'd0);
        seen_done = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (done || busy) seen_done = 1'b1;
        end
        chk("abort no done/busy", 32'(seen_done), 32'd0);

        do_op("repeat", 32'h1234_5678, 32'h1111_1111, 32'h0123_4567, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
